// File: rtl/sigmoid_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_pkg
// Shared definitions for the piecewise-linear sigmoid pipeline:
//   - 2-bit segment encoding produced by the classify half of each lane
//   - segment thresholds and offsets expressed as functions of the number of
//     fractional input bits, so the lane can be re-parameterised
//   - Galois LFSR tap mask and single-step helper used by the optional
//     Bernoulli sampler
// No ports (package).
// -----------------------------------------------------------------------------
package sigmoid_pkg;

    // Segment of |x| selected in S1 and consumed in S2.
    typedef enum logic [1:0] {
        SEG_LO  = 2'd0,     // |x| <  1.0
        SEG_MID = 2'd1,     // 1.0   <= |x| < 2.375
        SEG_HI  = 2'd2,     // 2.375 <= |x| < 5.0
        SEG_SAT = 2'd3      // |x| >= 5.0
    } seg_t;

    // 16-bit right-shifting Galois LFSR, taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Thresholds on |x| (inclusive lower bounds), FRAC_W fractional bits.
    function automatic int unsigned thr_sat(input int unsigned frac_w);
        return 32'd5 << frac_w;                 // 5.0
    endfunction

    function automatic int unsigned thr_hi(input int unsigned frac_w);
        return 32'd19 << (frac_w - 3);          // 2.375 = 19/8
    endfunction

    function automatic int unsigned thr_mid(input int unsigned frac_w);
        return 32'd1 << frac_w;                 // 1.0
    endfunction

    // Segment offsets, FRAC_W fractional bits.
    function automatic int unsigned off_hi(input int unsigned frac_w);
        return 32'd27 << (frac_w - 5);          // 0.84375 = 27/32
    endfunction

    function automatic int unsigned off_mid(input int unsigned frac_w);
        return 32'd5 << (frac_w - 3);           // 0.625 = 5/8
    endfunction

    function automatic int unsigned off_lo(input int unsigned frac_w);
        return 32'd1 << (frac_w - 1);           // 0.5
    endfunction

    // One Galois step: shift right, fold the tap mask in when a 1 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sigmoid_pipe_if.sv
// -----------------------------------------------------------------------------
// sigmoid_pipe_if
// Valid/ready bundle for the sigmoid pipeline: one input beat of LANES signed
// sums, one output beat of LANES unsigned probabilities plus sample bits.
//   in_valid / in_ready / in_sum            upstream (MAC accumulator) side
//   out_valid / out_ready / out_prob /
//   out_sample                              downstream (writeback) side
// Modports:
//   master - the environment driving sums and consuming probabilities
//   slave  - the sigmoid pipeline itself
// -----------------------------------------------------------------------------
interface sigmoid_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int LANES = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_sum;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_prob;
    logic [LANES-1:0]       out_sample;

    modport master (
        output in_valid, in_sum, out_ready,
        input  in_ready, out_valid, out_prob, out_sample
    );

    modport slave (
        input  in_valid, in_sum, out_ready,
        output in_ready, out_valid, out_prob, out_sample
    );
endinterface

// File: rtl/sigmoid_pwl_lane.sv
// -----------------------------------------------------------------------------
// sigmoid_pwl_lane
// Purely combinational single-lane piecewise-linear sigmoid, split in two
// halves around the S1 pipeline register owned by the parent:
//   classify half: x -> (s1_sign, s1_abs, s1_seg)
//   eval half    : (s2_sign, s2_abs, s2_seg) -> y
// Ports:
//   x        in  IN_W   signed sum, FRAC_W fractional bits
//   s1_sign  out 1      sign of x
//   s1_abs   out IN_W   |x|, most-negative input saturated to most-positive
//   s1_seg   out seg_t  segment of |x|
//   s2_sign  in  1      registered sign
//   s2_abs   in  IN_W   registered |x|
//   s2_seg   in  seg_t  registered segment
//   y        out OUT_W  unsigned probability, all-ones means 1.0
// -----------------------------------------------------------------------------
module sigmoid_pwl_lane
    import sigmoid_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 8
) (
    input  logic [IN_W-1:0]  x,
    output logic             s1_sign,
    output logic [IN_W-1:0]  s1_abs,
    output seg_t             s1_seg,
    input  logic             s2_sign,
    input  logic [IN_W-1:0]  s2_abs,
    input  seg_t             s2_seg,
    output logic [OUT_W-1:0] y
);

    // One guard bit above IN_W keeps offset additions and the 1.0 compare
    // free of wrap-around.
    localparam logic [IN_W:0] T_SAT   = (IN_W+1)'(thr_sat(FRAC_W));
    localparam logic [IN_W:0] T_HI    = (IN_W+1)'(thr_hi(FRAC_W));
    localparam logic [IN_W:0] T_MID   = (IN_W+1)'(thr_mid(FRAC_W));
    localparam logic [IN_W:0] OFF_HI  = (IN_W+1)'(off_hi(FRAC_W));
    localparam logic [IN_W:0] OFF_MID = (IN_W+1)'(off_mid(FRAC_W));
    localparam logic [IN_W:0] OFF_LO  = (IN_W+1)'(off_lo(FRAC_W));
    localparam logic [IN_W:0] ONE     = (IN_W+1)'(thr_mid(FRAC_W));

    localparam logic [IN_W-1:0] MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-1:0] MOST_POS = {1'b0, {(IN_W-1){1'b1}}};

    // Dropping fractional bits from FRAC_W down to OUT_W.
    localparam int SHIFT = FRAC_W - OUT_W;

    // ---------------- classify half (feeds S1) ----------------
    always_comb begin
        s1_sign = x[IN_W-1];
        // -(-2^(IN_W-1)) is not representable; pin it to the largest positive.
        if (x == MOST_NEG) begin
            s1_abs = MOST_POS;
        end else if (s1_sign) begin
            s1_abs = -x;
        end else begin
            s1_abs = x;
        end

        if ({1'b0, s1_abs} >= T_SAT) begin
            s1_seg = SEG_SAT;
        end else if ({1'b0, s1_abs} >= T_HI) begin
            s1_seg = SEG_HI;
        end else if ({1'b0, s1_abs} >= T_MID) begin
            s1_seg = SEG_MID;
        end else begin
            s1_seg = SEG_LO;
        end
    end

    // ---------------- eval half (feeds S2) ----------------
    logic [IN_W:0]    ypos_full;    // y+ at FRAC_W fractional bits
    logic [OUT_W-1:0] ypos_trunc;
    logic [OUT_W-1:0] ypos;

    always_comb begin
        case (s2_seg)
            SEG_HI:  ypos_full = {1'b0, s2_abs >> 5} + OFF_HI;
            SEG_MID: ypos_full = {1'b0, s2_abs >> 3} + OFF_MID;
            SEG_LO:  ypos_full = {1'b0, s2_abs >> 2} + OFF_LO;
            default: ypos_full = ONE;
        endcase
    end

    assign ypos_trunc = ypos_full[SHIFT +: OUT_W];
    // 1.0 itself does not fit in Q0.OUT_W; clamp to all-ones.
    assign ypos       = (ypos_full >= ONE) ? {OUT_W{1'b1}} : ypos_trunc;
    // all-ones minus y+ is a bitwise complement, so the fold can never wrap.
    assign y          = s2_sign ? ~ypos : ypos;

endmodule

// File: rtl/sigmoid_pipe.sv
// -----------------------------------------------------------------------------
// sigmoid_pipe
// Two-stage, LANES-wide piecewise-linear sigmoid between the MAC accumulator
// and the unit-state writeback. S1 holds sign, |x| and segment per lane; S2
// holds the final probability (and optional sample) per lane. All lanes share
// one valid/ready handshake. Latency 2 cycles, throughput 1 beat/cycle, bubbles
// collapse, outputs hold steady while stalled.
// Ports:
//   clk    in  1                rising-edge clock
//   rst_n  in  1                asynchronous active-low reset
//   bus    sigmoid_pipe_if.slave
//          in_valid/in_ready/in_sum (LANES*IN_W, lane i at [i*IN_W +: IN_W])
//          out_valid/out_ready/out_prob (LANES*OUT_W) /out_sample (LANES)
// Build option:
//   SIGMOID_SAMPLE_EN  when defined, a 16-bit Galois LFSR draws one Bernoulli
//                      sample per lane (out_sample[i] = y_i > r_i). Undefined:
//                      no LFSR, out_sample is constant 0.
// -----------------------------------------------------------------------------
module sigmoid_pipe
    import sigmoid_pkg::*;
#(
    parameter int          IN_W      = 16,
    parameter int          FRAC_W    = 8,
    parameter int          OUT_W     = 8,
    parameter int          LANES     = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    sigmoid_pipe_if.slave bus
);

    // ---------------- handshake ----------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s2_adv;       // S2 may take a new value this cycle
    logic s1_adv;       // S1 content moves into S2 this cycle
    logic in_ready;
    logic s1_load;      // a new beat is accepted into S1

    assign s2_adv   = ~s2_valid_reg | bus.out_ready;
    assign s1_adv   = s1_valid_reg & s2_adv;
    assign in_ready = ~s1_valid_reg | s2_adv;
    assign s1_load  = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= bus.in_valid;
            end
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
            end
        end
    end

    // ---------------- per-lane datapath ----------------
    logic [LANES-1:0][OUT_W-1:0] prob_pack;
    logic [LANES-1:0][OUT_W-1:0] y_pack;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic             sign_next;
            logic [IN_W-1:0]  abs_next;
            seg_t             seg_next;
            logic             sign_reg;
            logic [IN_W-1:0]  abs_reg;
            seg_t             seg_reg;
            logic [OUT_W-1:0] y_next;
            logic [OUT_W-1:0] prob_reg;

            sigmoid_pwl_lane #(
                .IN_W   (IN_W),
                .FRAC_W (FRAC_W),
                .OUT_W  (OUT_W)
            ) u_lane (
                .x       (bus.in_sum[gi*IN_W +: IN_W]),
                .s1_sign (sign_next),
                .s1_abs  (abs_next),
                .s1_seg  (seg_next),
                .s2_sign (sign_reg),
                .s2_abs  (abs_reg),
                .s2_seg  (seg_reg),
                .y       (y_next)
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sign_reg <= 1'b0;
                    abs_reg  <= '0;
                    seg_reg  <= SEG_LO;
                    prob_reg <= '0;
                end else begin
                    if (s1_load) begin
                        sign_reg <= sign_next;
                        abs_reg  <= abs_next;
                        seg_reg  <= seg_next;
                    end
                    if (s1_adv) begin
                        prob_reg <= y_next;
                    end
                end
            end

            assign prob_pack[gi] = prob_reg;
            assign y_pack[gi]    = y_next;
        end
    endgenerate

    assign bus.out_prob = prob_pack;

`ifdef SIGMOID_SAMPLE_EN
    // ---------------- Bernoulli sampler ----------------
    // The LFSR is unrolled LANES steps per S2 load; lane i draws from the
    // state after step i+1 (chain index gi+1). It only moves when S2 loads,
    // so a stall never changes the drawn sequence.
    logic [15:0]                 lfsr_reg;
    logic [LANES:0][15:0]        lfsr_chain;
    logic [LANES-1:0]            sample_next;
    logic [LANES-1:0]            sample_reg;

    assign lfsr_chain[0] = lfsr_reg;

    generate
        for (gi = 0; gi < LANES; gi++) begin : g_samp
            assign lfsr_chain[gi+1] = lfsr_step(lfsr_chain[gi]);
            assign sample_next[gi]  = (y_pack[gi] > lfsr_chain[gi+1][15 -: OUT_W]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg   <= LFSR_SEED;
            sample_reg <= '0;
        end else if (s1_adv) begin
            lfsr_reg   <= lfsr_chain[LANES];
            sample_reg <= sample_next;
        end
    end

    assign bus.out_sample = sample_reg;
`else
    // The S2 results are only needed for out_prob in this build.
    logic unused_y;
    assign unused_y       = ^y_pack;
    assign bus.out_sample = '0;
`endif

endmodule
